// File: rtl/mem_arb_pkg.sv
// Shared types and width helpers for the block-wide memory arbiter and its
// round-robin sub-arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_BLOCK_SIZE = 16;
  localparam int BLOCK_BITS_W   = DEF_BLOCK_SIZE * DEF_DATA_WIDTH;

  function automatic int block_bits(input int block_size, input int data_width);
    return block_size * data_width;
  endfunction

  // Index width that stays legal for a single requester as well.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after
// ptr (wrapping) wins; grant is one-hot, grant_idx its encoded index.
module rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  localparam int IW     = idx_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IW-1:0]      grant_idx,
  output logic               any_grant
);

  logic [IW-1:0] j_s;

  // Scan requesters in priority order starting at ptr.
  always_comb begin
    grant     = {NUM_REQ{1'b0}};
    grant_idx = {IW{1'b0}};
    any_grant = 1'b0;
    j_s       = {IW{1'b0}};
    for (int k = 0; k < NUM_REQ; k++) begin
      j_s = IW'((int'(ptr) + k) % NUM_REQ);
      if (!any_grant && req[j_s]) begin
        grant[j_s] = 1'b1;
        grant_idx  = j_s;
        any_grant  = 1'b1;
      end else begin
        any_grant  = any_grant;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one block-wide memory between NUM_REQ
// requesters; one transaction at a time, with a timeout error response.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int BLOCK_SIZE     = 16,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                    clk,
  input  logic                                    rst_n,
  input  logic [NUM_REQ-1:0]                      req_valid,
  output logic [NUM_REQ-1:0]                      req_ready,
  input  logic [NUM_REQ-1:0]                      req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]           req_addr,
  input  logic [NUM_REQ*BLOCK_SIZE*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                      resp_valid,
  output logic                                    resp_err,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]        resp_rdata,
  output logic [ADDR_WIDTH-1:0]                   mem_addr,
  output logic [BLOCK_SIZE*DATA_WIDTH-1:0]        mem_wdata,
  output logic                                    mem_read,
  output logic                                    mem_write,
  input  logic [BLOCK_SIZE*DATA_WIDTH-1:0]        mem_rdata,
  input  logic                                    mem_ready,
  input  logic                                    mem_hit
);

  localparam int BBW = block_bits(BLOCK_SIZE, DATA_WIDTH);
  localparam int IW  = idx_width(NUM_REQ);
  localparam int CW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};
  localparam logic [IW-1:0] IDX_LAST = IW'(NUM_REQ - 1);

  state_e           state_r;
  op_e              op_r;
  logic [IW-1:0]    owner_r;
  logic [IW-1:0]    last_grant_r;
  logic [CW-1:0]    cnt_r;

  logic [IW-1:0]    ptr_s;
  logic [NUM_REQ-1:0] grant_s;
  logic [IW-1:0]    grant_idx_s;
  logic             any_grant_s;
  logic             accept_s;
  logic             mem_done_s;
  logic             timeout_s;

  // Completion is decided by mem_ready alone; the hit flag carries no control.
  logic             unused_s;
  assign unused_s = mem_hit;

  function automatic logic [NUM_REQ-1:0] owner_onehot(input logic [IW-1:0] idx);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req       (req_valid),
    .ptr       (ptr_s),
    .grant     (grant_s),
    .grant_idx (grant_idx_s),
    .any_grant (any_grant_s)
  );

  // Priority pointer, acceptance and BUSY completion/timeout decisions.
  always_comb begin
    if (last_grant_r == IDX_LAST) begin
      ptr_s = {IW{1'b0}};
    end else begin
      ptr_s = last_grant_r + IW'(1);
    end
    if ((state_r == ST_IDLE) && rst_n) begin
      req_ready = grant_s;
    end else begin
      req_ready = {NUM_REQ{1'b0}};
    end
    accept_s   = any_grant_s && (state_r == ST_IDLE);
    // First BUSY cycle (cnt_r == 0) may still see the previous ready.
    mem_done_s = (state_r == ST_BUSY) && (cnt_r != {CW{1'b0}}) && mem_ready;
    timeout_s  = (state_r == ST_BUSY) && !mem_done_s && (cnt_r >= CNT_LAST);
  end

  // Transaction sequencer with registered memory strobes and responses.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      op_r         <= OP_READ;
      owner_r      <= {IW{1'b0}};
      last_grant_r <= IDX_LAST;
      cnt_r        <= {CW{1'b0}};
      resp_valid   <= {NUM_REQ{1'b0}};
      resp_err     <= 1'b0;
      resp_rdata   <= {BBW{1'b0}};
      mem_addr     <= {ADDR_WIDTH{1'b0}};
      mem_wdata    <= {BBW{1'b0}};
      mem_read     <= 1'b0;
      mem_write    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            owner_r      <= grant_idx_s;
            last_grant_r <= grant_idx_s;
            op_r         <= req_write[grant_idx_s] ? OP_WRITE : OP_READ;
            mem_addr     <= req_addr[grant_idx_s*ADDR_WIDTH +: ADDR_WIDTH];
            mem_wdata    <= req_wdata[grant_idx_s*BBW +: BBW];
            mem_read     <= ~req_write[grant_idx_s];
            mem_write    <= req_write[grant_idx_s];
            cnt_r        <= {CW{1'b0}};
            state_r      <= ST_BUSY;
          end else begin
            state_r      <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (mem_done_s) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= owner_onehot(owner_r);
            resp_err   <= 1'b0;
            resp_rdata <= (op_r == OP_READ) ? mem_rdata : {BBW{1'b0}};
            state_r    <= ST_RESP;
          end else if (timeout_s) begin
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            resp_valid <= owner_onehot(owner_r);
            resp_err   <= 1'b1;
            resp_rdata <= {BBW{1'b0}};
            state_r    <= ST_RESP;
          end else begin
            if (cnt_r != CNT_MAX) begin
              cnt_r <= cnt_r + CW'(1);
            end else begin
              cnt_r <= cnt_r;
            end
          end
        end
        ST_RESP: begin
          resp_valid <= {NUM_REQ{1'b0}};
          resp_err   <= 1'b0;
          state_r    <= ST_IDLE;
        end
        default: begin
          resp_valid <= {NUM_REQ{1'b0}};
          resp_err   <= 1'b0;
          mem_read   <= 1'b0;
          mem_write  <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a simple memory model (word i of a block
// at addr a reads as a+i) plus expected responses queued at acceptance.
module tb_mem_arbiter;

  localparam int DW  = 32;
  localparam int AW  = 32;
  localparam int BS  = 16;
  localparam int NR  = 2;
  localparam int TO  = 8;
  localparam int BBW = BS * DW;

  logic              clk;
  logic              rst_n;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR-1:0]     req_write;
  logic [NR*AW-1:0]  req_addr;
  logic [NR*BBW-1:0] req_wdata;
  logic [NR-1:0]     resp_valid;
  logic              resp_err;
  logic [BBW-1:0]    resp_rdata;
  logic [AW-1:0]     mem_addr;
  logic [BBW-1:0]    mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [BBW-1:0]    mem_rdata;
  logic              mem_ready;
  logic              mem_hit;

  mem_arbiter #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .BLOCK_SIZE     (BS),
    .NUM_REQ        (NR),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .mem_hit    (mem_hit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int             owner;
    logic           err;
    logic [BBW-1:0] rdata;
    int             lat;
    int             strobes;
    logic           wr;
    logic [AW-1:0]  addr;
    logic [BBW-1:0] wdata;
    int             acc_cyc;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   grant_log[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   strobe_cnt = 0;
  int   acc_total = 0;
  int   resp_total = 0;
  int   last_acc = -1;
  bit   spacing_on = 1'b0;
  int   mem_mode = 0;   // 0 normal, 1 never ready, 2 always ready
  bit   hit_zero = 1'b0;

  task automatic check(input string tag, input logic [BBW-1:0] got, input logic [BBW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [BBW-1:0] blk(input logic [AW-1:0] a);
    logic [BBW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = a + DW'(i);
    return b;
  endfunction

  function automatic logic [BBW-1:0] wpat(input int seed);
    logic [BBW-1:0] b;
    for (int i = 0; i < BS; i++) b[i*DW +: DW] = 32'hA500_0000 | (DW'(seed) << 8) | DW'(i);
    return b;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model.
  always @(posedge clk) begin
    if (!rst_n) mem_ready <= 1'b0;
    else case (mem_mode)
      0:       mem_ready <= (mem_read | mem_write) & ~mem_ready;
      1:       mem_ready <= 1'b0;
      default: mem_ready <= 1'b1;
    endcase
  end
  assign mem_rdata = blk(mem_addr);
  assign mem_hit   = hit_zero ? 1'b0 : mem_ready;

  // Monitor: scoreboard push on acceptance, pop and compare on response.
  always @(negedge clk) begin
    if (rst_n) begin
      if (resp_valid != '0) begin
        resp_total++;
        if (sb.size() == 0) begin
          check("resp_unexpected", BBW'(resp_valid), '0);
        end else begin
          mon_e = sb.pop_front();
          check("resp_owner", BBW'(resp_valid), BBW'(2'b01 << mon_e.owner));
          check("resp_err", BBW'(resp_err), BBW'(mon_e.err));
          check("resp_rdata", resp_rdata, mon_e.rdata);
          check("resp_latency", BBW'(cyc - mon_e.acc_cyc), BBW'(mon_e.lat));
          check("strobe_cycles", BBW'(strobe_cnt), BBW'(mon_e.strobes));
        end
      end
      if (mem_read | mem_write) begin
        if (sb.size() == 0) begin
          check("strobe_idle", BBW'({mem_write, mem_read}), '0);
        end else if (strobe_cnt == 0) begin
          check("mem_op", BBW'({mem_write, mem_read}), BBW'(sb[0].wr ? 2'b10 : 2'b01));
          check("mem_addr", BBW'(mem_addr), BBW'(sb[0].addr));
          if (sb[0].wr) check("mem_wdata", mem_wdata, sb[0].wdata);
        end
        strobe_cnt++;
      end
      if ((req_valid & req_ready) != '0) begin
        check("ready_onehot", BBW'($countones(req_ready)), BBW'(1));
        if (spacing_on && last_acc >= 0) check("accept_gap", BBW'(cyc - last_acc), BBW'(4));
        last_acc = cyc;
        for (int i = 0; i < NR; i++) begin
          if (req_valid[i] && req_ready[i]) begin
            mon_e.owner   = i;
            mon_e.wr      = req_write[i];
            mon_e.addr    = req_addr[i*AW +: AW];
            mon_e.wdata   = req_wdata[i*BBW +: BBW];
            mon_e.acc_cyc = cyc;
            if (mem_mode == 1) begin
              mon_e.err = 1'b1; mon_e.rdata = '0; mon_e.lat = TO + 1; mon_e.strobes = TO;
            end else begin
              mon_e.err = 1'b0; mon_e.lat = 3; mon_e.strobes = 2;
              mon_e.rdata = req_write[i] ? '0 : blk(req_addr[i*AW +: AW]);
            end
            sb.push_back(mon_e);
            grant_log.push_back(i);
            acc_total++;
            strobe_cnt = 0;
          end
        end
      end
    end
  end

  task automatic set_req(input int r, input bit wr, input logic [AW-1:0] a, input logic [BBW-1:0] wd);
    req_write[r]           = wr;
    req_addr[r*AW +: AW]   = a;
    req_wdata[r*BBW +: BBW] = wd;
    req_valid[r]           = 1'b1;
  endtask

  task automatic issue(input int r, input bit wr, input logic [AW-1:0] a,
                       input logic [BBW-1:0] wd, output int waited);
    bit ok = 1'b0;
    waited = 0;
    set_req(r, wr, a, wd);
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk);
      if (req_ready[r]) ok = 1'b1;
      else waited++;
    end
    check("accepted", BBW'(ok), BBW'(1));
    @(posedge clk); #1;
    req_valid[r] = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
    check("drain", BBW'(sb.size()), '0);
    @(posedge clk); #1;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_req_ready"}, BBW'(req_ready), '0);
    check({pfx, "_resp_valid"}, BBW'(resp_valid), '0);
    check({pfx, "_resp_err"}, BBW'(resp_err), '0);
    check({pfx, "_resp_rdata"}, resp_rdata, '0);
    check({pfx, "_mem_read"}, BBW'(mem_read), '0);
    check({pfx, "_mem_write"}, BBW'(mem_write), '0);
    check({pfx, "_mem_addr"}, BBW'(mem_addr), '0);
    check({pfx, "_mem_wdata"}, mem_wdata, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    int n_acc;
    int exp_g[4] = '{0, 1, 0, 1};
    rst_n = 1'b0; req_valid = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(posedge clk);
    #1 req_valid = 2'b11;
    @(negedge clk);
    check_all_zero("reset");
    @(posedge clk); #1;
    req_valid = '0;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single read from requester 0.
    issue(0, 1'b0, 32'h40, '0, w);
    check("t1_ready_cycle0", BBW'(w), '0);
    wait_done();

    // Write from requester 1, memory reporting hit=0.
    hit_zero = 1'b1;
    issue(1, 1'b1, 32'h20, wpat(1), w);
    wait_done();
    hit_zero = 1'b0;

    // Both requesters held: grants alternate, accepts 4 cycles apart.
    grant_log.delete();
    last_acc = -1;
    spacing_on = 1'b1;
    set_req(0, 1'b0, 32'h0, '0);
    set_req(1, 1'b0, 32'h100, '0);
    n_acc = 0;
    for (int k = 0; k < 60 && n_acc < 4; k++) begin
      @(negedge clk);
      if ((req_valid & req_ready) != '0) n_acc++;
    end
    check("rr_accepts", BBW'(n_acc), BBW'(4));
    @(posedge clk); #1;
    req_valid = '0;
    spacing_on = 1'b0;
    wait_done();
    check("rr_log_len", BBW'(grant_log.size()), BBW'(4));
    for (int i = 0; i < 4 && i < grant_log.size(); i++)
      check("rr_order", BBW'(grant_log[i]), BBW'(exp_g[i]));

    // Memory never answers: timeout error, then a normal request.
    mem_mode = 1;
    issue(0, 1'b0, 32'h200, '0, w);
    wait_done();
    mem_mode = 0;
    issue(1, 1'b0, 32'h300, '0, w);
    check("t4_next_accept", BBW'(w), '0);
    wait_done();

    // Ready held high: stale ready ignored, single response pulse.
    mem_mode = 2;
    issue(0, 1'b0, 32'h500, '0, w);
    wait_done();
    repeat (3) @(posedge clk);
    mem_mode = 0;
    repeat (2) @(posedge clk);
    #1;

    // Reset in the second BUSY cycle drops the transaction.
    issue(0, 1'b0, 32'h80, '0, w);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sb.delete();
    @(posedge clk); #1;
    @(negedge clk);
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    set_req(0, 1'b0, 32'h90, '0);
    set_req(1, 1'b0, 32'h190, '0);
    @(negedge clk);
    check("rr_after_reset", BBW'(req_ready), BBW'(2'b01));
    @(posedge clk); #1;
    req_valid = '0;
    wait_done();
    repeat (3) @(posedge clk);

    check("resp_count", BBW'(resp_total), BBW'(acc_total - 1));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
